// File: rtl/approx_div_pkg.sv
// Shared types and default sizing for the iterative approximate restoring divider.
package approx_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_N           = 8;
   localparam int DEF_APPROX_ROWS = 6;

endpackage

// File: rtl/approx_div_row.sv
// One combinational divider row: N-cell ripple-borrow subtractor, with an
// approximate cell variant (diff = x, bout = ~y) selected by `approx`.
module approx_div_row
   import approx_div_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic [N-1:0] x,
   input  logic         t,
   input  logic [N-1:0] d,
   input  logic         approx,
   output logic         q_bit,
   output logic [N-1:0] r_next
);

   logic [N:0]   borrow;
   logic [N-1:0] diff;

   always_comb begin
      borrow = '0;
      diff   = '0;
      for (int i = 0; i < N; i++) begin
         if (approx) begin
            diff[i]       = x[i];
            borrow[i+1]   = ~d[i];
         end else begin
            diff[i]       = x[i] ^ d[i] ^ borrow[i];
            borrow[i+1]   = (~x[i] & d[i]) | (~(x[i] ^ d[i]) & borrow[i]);
         end
      end
      // A set carried-out MSB (t) means the partial remainder already exceeds d.
      q_bit  = t | ~borrow[N];
      r_next = q_bit ? diff : x;
   end

endmodule

// File: rtl/approx_div_iter.sv
// Iterative restoring divider, one quotient row per clock, low rows approximate.
// Optional APPROX_DIV_MODE_EN adds exact_mode to force all rows exact per operation.
module approx_div_iter
   import approx_div_pkg::*;
#(
   parameter int N           = DEF_N,
   parameter int APPROX_ROWS = DEF_APPROX_ROWS
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] n,
   input  logic [N-1:0]   d,
`ifdef APPROX_DIV_MODE_EN
   input  logic           exact_mode,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   q,
   output logic [N-1:0]   r,
   output logic           busy
);

   localparam int JW = (N > 1) ? $clog2(N) : 1;

   state_t         state_q, state_d;
   logic [N-1:0]   n_lo_q, n_lo_d;
   logic [N-1:0]   d_q, d_d;
   logic [N-1:0]   r_q, r_d;
   logic [N-1:0]   q_q, q_d;
   logic [JW-1:0]  j_q, j_d;
   logic           approx;
   logic           row_q_bit;
   logic [N-1:0]   row_r;
   logic [N-1:0]   x;

`ifdef APPROX_DIV_MODE_EN
   logic           exact_q, exact_d;
   assign approx = (int'(j_q) < APPROX_ROWS) & ~exact_q;
`else
   assign approx = (int'(j_q) < APPROX_ROWS);
`endif

   assign x = {r_q[N-2:0], n_lo_q[j_q]};

   approx_div_row #(.N(N)) u_row (
      .x      (x),
      .t      (r_q[N-1]),
      .d      (d_q),
      .approx (approx),
      .q_bit  (row_q_bit),
      .r_next (row_r)
   );

   always_comb begin
      state_d = state_q;
      n_lo_d  = n_lo_q;
      d_d     = d_q;
      r_d     = r_q;
      q_d     = q_q;
      j_d     = j_q;
`ifdef APPROX_DIV_MODE_EN
      exact_d = exact_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = BUSY;
               n_lo_d  = n[N-1:0];
               d_d     = d;
               r_d     = n[2*N-1:N];
               q_d     = '0;
               j_d     = JW'(N - 1);
`ifdef APPROX_DIV_MODE_EN
               exact_d = exact_mode;
`endif
            end
         end
         BUSY: begin
            q_d[j_q] = row_q_bit;
            r_d      = row_r;
            if (j_q == '0) state_d = DONE;
            else           j_d     = j_q - 1'b1;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_lo_q  <= '0;
         d_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         j_q     <= '0;
`ifdef APPROX_DIV_MODE_EN
         exact_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         n_lo_q  <= n_lo_d;
         d_q     <= d_d;
         r_q     <= r_d;
         q_q     <= q_d;
         j_q     <= j_d;
`ifdef APPROX_DIV_MODE_EN
         exact_q <= exact_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == BUSY);
   assign q         = q_q;
   assign r         = r_q;

endmodule

// File: tb/tb_approx_div_iter.sv
// Bench for approx_div_iter: two instances (APPROX_ROWS = 0 and 6) share stimulus
// and are checked against an arithmetic row-by-row reference model.
module tb_approx_div_iter;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          ex_mode = 1'b0;
   logic [2*N-1:0] n_in = '0;
   logic [N-1:0]  d_in = '0;

   logic          ira, ova, busya, irb, ovb, busyb;
   logic [N-1:0]  qa, ra, qb, rb;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   approx_div_iter #(.N(N), .APPROX_ROWS(0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ira),
      .n(n_in), .d(d_in),
`ifdef APPROX_DIV_MODE_EN
      .exact_mode(ex_mode),
`endif
      .out_valid(ova), .out_ready(out_ready), .q(qa), .r(ra), .busy(busya)
   );

   approx_div_iter #(.N(N), .APPROX_ROWS(6)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irb),
      .n(n_in), .d(d_in),
`ifdef APPROX_DIV_MODE_EN
      .exact_mode(ex_mode),
`endif
      .out_valid(ovb), .out_ready(out_ready), .q(qb), .r(rb), .busy(busyb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Restoring division evaluated row by row with integer arithmetic.
   function automatic void ref_div(input logic [15:0] nn, input logic [7:0] dd,
                                   input int ar, input bit ex,
                                   output logic [7:0] qq, output logic [7:0] rr);
      int rem, x, t;
      rem = int'(nn[15:8]);
      qq  = '0;
      for (int j = 7; j >= 0; j--) begin
         x = ((rem * 2) % 256) + int'(nn[j]);
         t = rem / 128;
         if (j >= ar || ex) begin
            if (t == 1 || x >= int'(dd)) begin
               qq[j] = 1'b1;
               rem   = (x - int'(dd) + 256) % 256;
            end else begin
               rem = x;
            end
         end else begin
            qq[j] = (t == 1) || dd[7];
            rem   = x;
         end
      end
      rr = rem[7:0];
   endfunction

   // Issue one operation, check latency and both results, optionally stall in DONE.
   task automatic run_op(input logic [15:0] nn, input logic [7:0] dd, input bit ex,
                         input int hold);
      logic [7:0] eqa, era, eqb, erb;
      int lat;
      for (int k = 0; k < 3 * N && !ira; k++) tick();
      chk("in_ready_before_op", 32'(ira), 32'd1);
      n_in     = nn;
      d_in     = dd;
      ex_mode  = ex;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("busy_after_accept", 32'({busya, busyb, ira}), 32'b110);
      ref_div(nn, dd, 0, ex, eqa, era);
      ref_div(nn, dd, 6, ex, eqb, erb);
      lat = 0;
      while (!ova && lat < 3 * N) begin
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'(N));
      chk("q_rows0", 32'(qa), 32'(eqa));
      chk("r_rows0", 32'(ra), 32'(era));
      chk("q_rows6", 32'(qb), 32'(eqb));
      chk("r_rows6", 32'(rb), 32'(erb));
      for (int h = 0; h < hold; h++) begin
         if (h == 0) begin
            n_in     = 16'($urandom);
            d_in     = 8'($urandom);
            ex_mode  = ~ex;
            in_valid = 1'b1;
         end
         tick();
         in_valid = 1'b0;
         chk("hold_handshake", 32'({ova, ovb, ira, irb, busya}), 32'b11000);
         chk("hold_q_r", {qa, ra, qb, rb}, {eqa, era, eqb, erb});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("back_to_idle", 32'({ova, ira, busya}), 32'b010);
   endtask

   initial begin
      logic [15:0] rn;
      logic [7:0]  rd;
      bit          seen;

      #2 rst_n = 1'b0;
      #10;
      chk("reset_outputs", {qa, ra, qb, rb}, 32'd0);
      chk("reset_flags", 32'({ova, busya, ira, ovb, busyb, irb}), 32'b001001);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset", 32'({ira, ova}), 32'b10);

      run_op(16'd1000, 8'd7, 1'b0, 0);
      chk("const_q_rows0", 32'(qa), 32'd142);
      chk("const_r_rows0", 32'(ra), 32'd6);

      run_op(16'd1000, 8'd7, 1'b0, 1);
      chk("const_q_rows6", 32'(qb), 32'd128);
      chk("const_r_rows6", 32'(rb), 32'd104);

      run_op(16'd0, 8'h80, 1'b0, 0);
      chk("const_q_d80", 32'(qb), 32'h3F);
      chk("const_r_d80", 32'(rb), 32'd0);

      run_op(16'h5A3C, 8'd0, 1'b0, 0);
      run_op(16'hFFFF, 8'd1, 1'b0, 3);

`ifdef APPROX_DIV_MODE_EN
      run_op(16'd1000, 8'd7, 1'b1, 0);
      chk("exact_mode_q", 32'(qb), 32'd142);
      chk("exact_mode_r", 32'(rb), 32'd6);
`endif

      for (int i = 0; i < 24; i++) begin
         rn = 16'($urandom);
         rd = (i % 6 == 5) ? 8'd0 : 8'($urandom);
`ifdef APPROX_DIV_MODE_EN
         run_op(rn, rd, 1'($urandom), $urandom_range(0, 3));
`else
         run_op(rn, rd, 1'b0, $urandom_range(0, 3));
`endif
      end

      // Abort mid-BUSY with an asynchronous reset.
      n_in     = 16'd1000;
      d_in     = 8'd7;
      ex_mode  = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("busy_cycle4", 32'(busya), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {qa, ra, qb, rb}, 32'd0);
      chk("abort_flags", 32'({ova, busya, ovb, busyb}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("abort_in_ready", 32'({ira, irb}), 32'b11);
      seen = 1'b0;
      for (int k = 0; k < 2 * N; k++) begin
         tick();
         if (ova || ovb || busya) seen = 1'b1;
      end
      chk("abort_no_result", 32'(seen), 32'd0);

      run_op(16'h1234, 8'h56, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/approx_div_iter.md
APPROX_DIV_ITER -- requirements
Module: approx_div_iter

Interface
REQ-001 SHALL have parameter N, default 8, giving the divisor, quotient and remainder width; the dividend is 2N bits.
REQ-002 SHALL have parameter APPROX_ROWS, default 6, range 0..N: quotient rows j < APPROX_ROWS use the approximate cell.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  dividend and divisor valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 n  input  2N  dividend.
REQ-008 d  input  N  divisor.
REQ-009 out_valid  output  1  q and r valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 q  output  N  quotient.
REQ-012 r  output  N  remainder.
REQ-013 busy  output  1  high while in BUSY state.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 Accept SHALL occur on in_valid & in_ready; n, d and row counter j = N-1 are registered, and R is initialised to n[2N-1:N].
REQ-016 BUSY SHALL compute one row per clock, j = N-1 down to 0, for exactly N cycles, then enter DONE.
REQ-017 Row j SHALL form x = {R[N-2:0], n[j]} and t = R[N-1].
REQ-018 Exact row (j >= APPROX_ROWS): q[j] = t | (x >= d); R <= q[j] ? (x - d) mod 2^N : x.
REQ-019 Approximate row (j < APPROX_ROWS): the per-bit cell is diff = x, bout = ~y, so q[j] = t | d[N-1] and R <= x.
REQ-020 After row 0, r SHALL equal R; q and r SHALL hold stable throughout DONE.
REQ-021 DONE -> IDLE SHALL occur on out_ready; while out_ready is low, DONE is held indefinitely.
REQ-022 Latency: out_valid SHALL rise N clock edges after the accept edge; throughput is one operation per N+2 cycles minimum.
REQ-023 in_valid during BUSY or DONE SHALL be ignored, with no effect on the operation in flight.
REQ-024 d = 0 SHALL need no special case and SHALL follow REQ-018/019 (exact rows give q[j] = 1, R = x).
REQ-025 Overflow (n[2N-1:N] >= d) SHALL not be flagged; the result is per the row equations only.

Reset
REQ-026 rst_n low SHALL force, asynchronously, state IDLE, q = 0, r = 0, R = 0, j = 0, out_valid = 0, busy = 0, and in_ready = 1 after release.
REQ-027 Reset asserted mid-BUSY or in DONE SHALL abort the operation; no result is presented after release.

Configuration
REQ-028 Macro APPROX_DIV_MODE_EN defined SHALL add input exact_mode (1 bit), registered at accept; exact_mode = 1 forces every row exact for that operation.
REQ-029 Macro APPROX_DIV_MODE_EN undefined: no exact_mode port; row type is set by APPROX_ROWS alone.

Structure
REQ-030 Package approx_div_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the default constants N = 8 and APPROX_ROWS = 6.
REQ-031 Sub-module approx_div_row SHALL be the single combinational row: inputs x, t, d, approx; outputs q_bit, r_next, with a ripple borrow chain of N cells.

Verification (N = 8)
REQ-032 APPROX_ROWS = 0, n = 1000, d = 7 -> q = 142, r = 6; out_valid rises 8 edges after accept.
REQ-033 APPROX_ROWS = 6, n = 1000, d = 7 -> q = 128, r = 104.
REQ-034 APPROX_ROWS = 6, n = 0, d = 0x80 -> q = 0x3F, r = 0.
REQ-035 Back-pressure: out_ready held low 3 cycles in DONE -> q, r and out_valid stable, in_ready = 0, and a new in_valid pulse is ignored.
REQ-036 rst_n pulsed low at BUSY cycle 4 -> outputs 0 immediately; after release, in_ready = 1 and out_valid never asserts for the aborted operation.
REQ-037 With APPROX_DIV_MODE_EN: APPROX_ROWS = 6, exact_mode = 1, n = 1000, d = 7 -> q = 142, r = 6.
